viterbi_tb_sched: RTL and testbench

VITERBI_TB_SCHED -- requirements
Module: viterbi_tb_sched

---
 rtl/viterbi_pkg.sv | 14 +
 rtl/tb_addr_gen.sv | 44 ++++
 rtl/viterbi_tb_sched.sv | 191 +++++++++++++++++++
 tb/tb_viterbi_tb_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared Viterbi traceback scheduler types and default dimensions
package viterbi_pkg;
  localparam int TB_LEN_DEF  = 16;
  localparam int DEC_LEN_DEF = 8;
  localparam int AW_DEF      = 5;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    TRACE,
    FLUSH,
    DONE
  } tb_state_t;
endpackage

// File: rtl/tb_addr_gen.sv
// rtl/tb_addr_gen.sv - loadable survivor-memory read down-counter with step count and decode flags
module tb_addr_gen #(
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_adv,
  input  logic [AW-1:0] i_load_addr,
  input  logic [AW:0]   i_load_len,
  input  logic [AW:0]   i_load_dec_start,
  output logic [AW-1:0] o_addr,
  output logic          o_first,
  output logic          o_last,
  output logic          o_dec
);
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_step;
  logic [AW:0]   r_len;
  logic [AW:0]   r_dec_start;

  // A load on the same cycle as the final read wins, so back-to-back tracebacks have no gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_step      <= '0;
      r_len       <= '0;
      r_dec_start <= '0;
    end else if (i_load) begin
      r_addr      <= i_load_addr;
      r_step      <= '0;
      r_len       <= i_load_len;
      r_dec_start <= i_load_dec_start;
    end else if (i_adv) begin
      r_addr <= r_addr - AW'(1);
      r_step <= r_step + (AW+1)'(1);
    end
  end

  assign o_addr  = r_addr;
  assign o_first = (r_step == '0);
  assign o_last  = (r_step == r_len - (AW+1)'(1));
  assign o_dec   = (r_step >= r_dec_start);
endmodule

// File: rtl/viterbi_tb_sched.sv
// rtl/viterbi_tb_sched.sv - survivor-memory write/traceback/flush scheduler for a Viterbi decoder
module viterbi_tb_sched
  import viterbi_pkg::*;
#(
  parameter int TB_LEN  = TB_LEN_DEF,
  parameter int DEC_LEN = DEC_LEN_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_col_valid,
  input  logic          i_frame_end,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_tb_start,
  output logic          o_tb_zero,
  output logic          o_dec_valid,
  output logic          o_dec_last,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_overflow
);
  localparam logic [AW:0] L_TB   = (AW+1)'(TB_LEN);
  localparam logic [AW:0] L_TOT  = (AW+1)'(TB_LEN + DEC_LEN);
  localparam logic [AW:0] L_ZERO = '0;

  tb_state_t     r_state;
  tb_state_t     w_next;
  logic [AW-1:0] r_wr_addr;
  logic [AW:0]   r_undec;
  logic          r_fe;
  logic          r_pend;
  logic [AW-1:0] r_pend_addr;
  logic          r_ovf;

  logic          w_wr;
  logic          w_rd;
  logic          w_trig;
  logic          w_fe_any;
  logic [AW:0]   w_undec_inc;
  logic [AW:0]   w_undec_nxt;
  logic [AW-1:0] w_last_wr;
  logic [AW-1:0] w_g_addr;
  logic          w_g_first;
  logic          w_g_last;
  logic          w_g_dec;
  logic          w_load;
  logic [AW-1:0] w_load_addr;
  logic [AW:0]   w_load_len;
  logic [AW:0]   w_load_dec;
  logic          w_pend_nxt;
  logic [AW-1:0] w_pend_addr_nxt;
  logic          w_ovf_set;

  assign w_wr        = i_en & i_col_valid & ((r_state == RUN) | (r_state == TRACE));
  assign w_rd        = i_en & ((r_state == TRACE) | (r_state == FLUSH));
  assign w_undec_inc = r_undec + (AW+1)'(1);
  assign w_trig      = w_wr & (w_undec_inc == L_TOT);
  assign w_undec_nxt = !w_wr ? r_undec : (w_trig ? L_TB : w_undec_inc);
  assign w_fe_any    = r_fe | (w_wr & i_frame_end);
  // Flush starts at the most recently written column, including one written this cycle.
  assign w_last_wr   = w_wr ? r_wr_addr : r_wr_addr - AW'(1);

  tb_addr_gen #(.AW(AW)) u_addr_gen (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_load          (w_load & i_en),
    .i_adv           (w_rd),
    .i_load_addr     (w_load_addr),
    .i_load_len      (w_load_len),
    .i_load_dec_start(w_load_dec),
    .o_addr          (w_g_addr),
    .o_first         (w_g_first),
    .o_last          (w_g_last),
    .o_dec           (w_g_dec)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_load          = 1'b0;
    w_load_addr     = r_wr_addr;
    w_load_len      = L_TOT;
    w_load_dec      = L_TB;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_ovf_set       = 1'b0;
    case (r_state)
      IDLE: w_next = RUN;
      RUN: begin
        if (w_trig) begin
          w_next = TRACE;
          w_load = 1'b1;
        end else if (w_fe_any) begin
          w_next      = FLUSH;
          w_load      = 1'b1;
          w_load_addr = w_last_wr;
          w_load_len  = w_undec_nxt;
          w_load_dec  = L_ZERO;
        end
      end
      TRACE: begin
        if (w_rd && w_g_last) begin
          // The pending slot drains on the final read, so a trigger here refills it.
          if (r_pend) begin
            w_load          = 1'b1;
            w_load_addr     = r_pend_addr;
            w_pend_nxt      = w_trig;
            w_pend_addr_nxt = r_wr_addr;
          end else if (w_trig) begin
            w_load = 1'b1;
          end else if (w_fe_any) begin
            w_next      = FLUSH;
            w_load      = 1'b1;
            w_load_addr = w_last_wr;
            w_load_len  = w_undec_nxt;
            w_load_dec  = L_ZERO;
          end else begin
            w_next = RUN;
          end
        end else if (w_trig) begin
          if (r_pend) begin
            w_ovf_set = 1'b1;
          end else begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = r_wr_addr;
          end
        end
      end
      FLUSH: begin
        if (w_rd && w_g_last) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_addr   <= '0;
      r_undec     <= '0;
      r_fe        <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_ovf       <= 1'b0;
    end else if (i_en) begin
      if (r_state == DONE) begin
        r_wr_addr <= '0;
        r_undec   <= '0;
        r_fe      <= 1'b0;
      end else begin
        if (w_wr) begin
          r_wr_addr <= r_wr_addr + AW'(1);
          r_undec   <= w_undec_nxt;
          if (i_frame_end) begin
            r_fe <= 1'b1;
          end
        end
        r_pend      <= w_pend_nxt;
        r_pend_addr <= w_pend_addr_nxt;
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign o_wr_en      = w_wr;
  assign o_wr_addr    = r_wr_addr;
  assign o_rd_en      = w_rd;
  assign o_rd_addr    = w_g_addr;
  assign o_tb_start   = w_rd & w_g_first;
  assign o_tb_zero    = w_rd & w_g_first & (r_state == FLUSH);
  assign o_dec_valid  = w_rd & w_g_dec;
  assign o_dec_last   = w_rd & w_g_last;
  assign o_busy       = (r_state != IDLE);
  assign o_frame_done = i_en & (r_state == DONE);
  assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_viterbi_tb_sched.sv
// tb/tb_viterbi_tb_sched.sv - randomized scheduler bench against a traceback job-queue model
module tb_viterbi_tb_sched;
  localparam int TB = 16;
  localparam int DL = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic cv = 1'b0;
  logic fe = 1'b0;
  logic wr_en, rd_en, tb_start, tb_zero, dec_valid, dec_last, busy, frame_done, overflow;
  logic [AW-1:0] wr_addr, rd_addr;

  viterbi_tb_sched #(.TB_LEN(TB), .DEC_LEN(DL), .AW(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_col_valid (cv),
    .i_frame_end (fe),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .o_tb_start  (tb_start),
    .o_tb_zero   (tb_zero),
    .o_dec_valid (dec_valid),
    .o_dec_last  (dec_last),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: one active read job (traceback or flush) plus a queue of waiting traceback starts.
  typedef struct {
    int addr;
    int len;
    int dec_from;
    bit zero;
  } job_t;

  job_t m_cur;
  job_t m_wait[$];
  bit   m_has_cur, m_run, m_done, m_fe, m_ovf;
  int   m_step, m_wp, m_undec;

  int ob_zero_addr, ob_fl_reads, ob_dec_cnt, ob_dl_addr, ob_done_cnt;
  bit ob_in_fl, ob_wrap, ob_prev_rd_en;
  int ob_prev_rd;
  int ar;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic model_reset();
    m_has_cur = 0;
    m_wait.delete();
    m_run = 0;
    m_done = 0;
    m_fe = 0;
    m_ovf = 0;
    m_step = 0;
    m_wp = 0;
    m_undec = 0;
  endtask

  task automatic check_outputs();
    bit act, erd;
    act = m_run && !m_done && !(m_has_cur && m_cur.zero);
    erd = en && m_has_cur;
    chk("wr_en", wr_en, en && cv && act);
    chk("wr_addr", wr_addr, m_wp);
    chk("rd_en", rd_en, erd);
    if (m_has_cur) chk("rd_addr", rd_addr, (m_cur.addr - m_step + DEPTH) % DEPTH);
    chk("tb_start", tb_start, erd && m_step == 0);
    chk("tb_zero", tb_zero, erd && m_step == 0 && m_cur.zero);
    chk("dec_valid", dec_valid, erd && m_step >= m_cur.dec_from);
    chk("dec_last", dec_last, erd && m_step == m_cur.len - 1);
    chk("busy", busy, m_run);
    chk("frame_done", frame_done, en && m_done);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic model_step();
    bit fin, trig, wr;
    int taddr;
    job_t j;
    if (!en) return;
    if (!m_run) begin m_run = 1; return; end
    if (m_done) begin
      m_done = 0; m_run = 0; m_wp = 0; m_undec = 0; m_fe = 0;
      return;
    end
    wr = cv && !(m_has_cur && m_cur.zero);
    fin = m_has_cur && (m_step == m_cur.len - 1);
    trig = 0;
    taddr = 0;
    if (wr) begin
      taddr = m_wp;
      m_wp = (m_wp + 1) % DEPTH;
      m_undec++;
      if (fe) m_fe = 1;
      if (m_undec == TB + DL) begin m_undec = TB; trig = 1; end
    end
    if (m_has_cur) begin
      if (fin && m_cur.zero) begin m_has_cur = 0; m_done = 1; return; end
      m_step++;
      if (fin) m_has_cur = 0;
    end
    if (trig) begin
      j.addr = taddr; j.len = TB + DL; j.dec_from = TB; j.zero = 0;
      m_wait.push_back(j);
    end
    if (!m_has_cur && m_wait.size() > 0) begin
      m_cur = m_wait.pop_front(); m_step = 0; m_has_cur = 1;
    end
    if (m_wait.size() > 1) begin
      m_wait.delete(m_wait.size() - 1);
      m_ovf = 1;
    end
    if (!m_has_cur && m_fe) begin
      m_cur.addr = (m_wp + DEPTH - 1) % DEPTH;
      m_cur.len = m_undec;
      m_cur.dec_from = 0;
      m_cur.zero = 1;
      m_step = 0;
      m_has_cur = 1;
    end
  endtask

  task automatic observe();
    if (rd_en && tb_zero) begin ob_in_fl = 1; ob_zero_addr = rd_addr; ob_fl_reads = 0; end
    if (rd_en && ob_in_fl) ob_fl_reads++;
    if (dec_valid) ob_dec_cnt++;
    if (dec_last) ob_dl_addr = rd_addr;
    if (frame_done) begin ob_done_cnt++; ob_in_fl = 0; end
    if (rd_en && ob_prev_rd_en && ob_prev_rd == 0 && rd_addr == DEPTH - 1) ob_wrap = 1;
    ob_prev_rd_en = rd_en;
    ob_prev_rd = rd_addr;
  endtask

  task automatic cyc(input bit e, input bit c, input bit f);
    @(negedge clk);
    en = e; cv = c; fe = f;
    #1;
    check_outputs();
    observe();
    model_step();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    en = 0; cv = 0; fe = 0; rst = 1;
    #1;
    chk({tag, "_outs"}, {wr_en, rd_en, tb_start, tb_zero, dec_valid, dec_last, busy, frame_done, overflow}, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    model_reset();
    ob_in_fl = 0; ob_wrap = 0; ob_prev_rd_en = 0; ob_prev_rd = 0;
    ob_zero_addr = -1; ob_fl_reads = 0; ob_dec_cnt = 0; ob_dl_addr = -1; ob_done_cnt = 0;
    do_reset("por");

    // 24 back-to-back writes, then the first traceback
    cyc(1, 0, 0);
    ob_dec_cnt = 0;
    repeat (24) cyc(1, 1, 0);
    cyc(1, 0, 0);
    chk("b_tb_start", tb_start, 1);
    chk("b_first_rd", rd_addr, 23);
    repeat (23) cyc(1, 0, 0);
    chk("b_dec_cnt", ob_dec_cnt, DL);
    chk("b_dl_addr", ob_dl_addr, 0);
    cyc(1, 0, 0);

    // continuous writes: wrap, pending trigger, dropped trigger
    ob_wrap = 0;
    repeat (60) cyc(1, 1, 0);
    chk("c_overflow", overflow, 1);
    chk("c_rd_wrap", ob_wrap, 1);

    // enable freeze mid-traceback
    cyc(1, 0, 0);
    ar = rd_addr;
    repeat (5) cyc(0, 1, 1);
    chk("frz_rd_en", rd_en, 0);
    chk("frz_addr", rd_addr, (ar + DEPTH - 1) % DEPTH);
    cyc(1, 0, 0);
    chk("resume_rd_en", rd_en, 1);
    chk("resume_addr", rd_addr, (ar + DEPTH - 1) % DEPTH);
    cyc(1, 0, 0);
    chk("resume_next", rd_addr, (ar + DEPTH - 2) % DEPTH);

    // random enable and column gaps
    for (int k = 0; k < 200; k++) cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, 0);
    chk("d_ovf_held", overflow, 1);

    // reset in the middle of a traceback
    for (int k = 0; k < 80 && !(rd_en && !tb_zero); k++) cyc(1, 1, 0);
    chk("e_in_trace", rd_en, 1);
    do_reset("mid_trace");
    cyc(0, 0, 0);

    // 30-column frame with flush
    ob_done_cnt = 0;
    cyc(1, 0, 0);
    repeat (29) cyc(1, 1, 0);
    cyc(1, 1, 1);
    for (int k = 0; k < 200 && ob_done_cnt == 0; k++) cyc(1, 0, 0);
    chk("f_done", ob_done_cnt, 1);
    chk("f_fl_reads", ob_fl_reads, 22);
    chk("f_zero_addr", ob_zero_addr, 29);
    chk("f_dl_addr", ob_dl_addr, 8);
    cyc(1, 0, 0);
    chk("f_idle", busy, 0);

    // random frames
    for (int fr = 0; fr < 2; fr++) begin
      int nw;
      nw = $urandom_range(3, 70);
      ob_done_cnt = 0;
      cyc(1, 0, 0);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 3) == 0) cyc($urandom_range(0, 1) == 1, 0, 1);
        cyc(1, 1, i == nw - 1);
      end
      for (int k = 0; k < 300 && ob_done_cnt == 0; k++) cyc($urandom_range(0, 4) != 0, 0, 0);
      chk("g_done", ob_done_cnt, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
